// File: rtl/step_count_checker_pkg.sv
// Shared types and constant helpers for the stepped-count checker.
package step_count_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = 32'(i + 1);
            end
        end
        return result;
    endfunction

    function automatic int unsigned err_max(input int unsigned width);
        return 32'((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/step_count_checker_sat_counter.sv
// Saturating up-counter: adds 0..2 per cycle, sync clear applied before the add.
module sat_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [WIDTH-1:0] count
);

    localparam int unsigned SW = WIDTH + 2;

    logic [SW-1:0]    base;
    logic [SW-1:0]    sum;
    logic [WIDTH-1:0] count_nxt;

    always_comb begin
        base      = clr ? '0 : SW'(count);
        sum       = base + SW'(inc);
        count_nxt = (sum > SW'(MAX)) ? WIDTH'(MAX) : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || (inc != 2'd0)) begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/step_count_checker.sv
// Monitors a stepped counter: emits a step event per new value and flags
// run-length and increment-sequence violations.
module step_count_checker
    import step_count_checker_pkg::*;
#(
    parameter int unsigned W     = 2,
    parameter int unsigned HOLD  = 5,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     cnt_in,
    input  logic             clr_err,
    output logic             step_valid,
    output logic [W-1:0]     step_value,
    output logic             locked,
    output logic             hold_err,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned RUN_W   = clog2(HOLD + 2);
    localparam int unsigned ERR_MAX = err_max(ERR_W);

    state_t           state_q, state_d;
    logic [W-1:0]     prev_q, prev_d;
    logic             long_q, long_d;
    logic [RUN_W-1:0] run_len;
    logic             run_clr;
    logic [1:0]       run_inc;
    logic             step_valid_d;
    logic [W-1:0]     step_value_d;
    logic             hold_e, seq_e;
    logic             same_c, inc_ok_c;
    logic [1:0]       err_inc;

    // Run length in samples of the current value; a change reloads it to 1.
    sat_counter #(.WIDTH(RUN_W), .MAX(HOLD + 1)) u_run_len (
        .clk   (clk),
        .rst   (rst),
        .clr   (run_clr),
        .inc   (run_inc),
        .count (run_len)
    );

    sat_counter #(.WIDTH(ERR_W), .MAX(ERR_MAX)) u_err_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_err),
        .inc   (err_inc),
        .count (err_count)
    );

    assign err_inc = {1'b0, hold_e} + {1'b0, seq_e};

    // Next-state and event decode
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        long_d       = long_q;
        run_clr      = 1'b0;
        run_inc      = 2'd0;
        step_valid_d = 1'b0;
        step_value_d = step_value;
        hold_e       = 1'b0;
        seq_e        = 1'b0;
        same_c       = (cnt_in == prev_q);
        inc_ok_c     = (cnt_in == prev_q + W'(1));

        if (en) begin
            unique case (state_q)
                IDLE: begin
                    prev_d  = cnt_in;
                    run_clr = 1'b1;
                    run_inc = 2'd1;
                    long_d  = 1'b0;
                    state_d = ACQUIRE;
                end
                ACQUIRE, TRACK: begin
                    if (same_c) begin
                        run_inc = 2'd1;
                        // Long run is reported once, on the first repeat past HOLD
                        if ((state_q == TRACK) && (run_len >= RUN_W'(HOLD)) && !long_q) begin
                            hold_e = 1'b1;
                            long_d = 1'b1;
                        end
                    end else begin
                        step_valid_d = 1'b1;
                        step_value_d = cnt_in;
                        prev_d       = cnt_in;
                        run_clr      = 1'b1;
                        run_inc      = 2'd1;
                        long_d       = 1'b0;
                        hold_e       = (state_q == TRACK) && (run_len < RUN_W'(HOLD));
                        seq_e        = !inc_ok_c;
                        state_d      = inc_ok_c ? TRACK : ACQUIRE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            long_q     <= 1'b0;
            step_valid <= 1'b0;
            step_value <= '0;
            locked     <= 1'b0;
            hold_err   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            long_q     <= long_d;
            step_valid <= step_valid_d;
            step_value <= step_value_d;
            locked     <= (state_d == TRACK);
            hold_err   <= (clr_err ? 1'b0 : hold_err) | hold_e;
            seq_err    <= (clr_err ? 1'b0 : seq_err) | seq_e;
        end
    end

endmodule

// File: tb/tb_step_count_checker.sv
// Self-checking bench for step_count_checker against a sample-level reference model.
module tb_step_count_checker;

    localparam int unsigned W     = 2;
    localparam int unsigned HOLD  = 5;
    localparam int unsigned ERR_W = 8;
    localparam int MOD     = 4;
    localparam int ERR_MAX = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [W-1:0]     cnt_in;
    logic             clr_err;
    logic             step_valid;
    logic [W-1:0]     step_value;
    logic             locked;
    logic             hold_err;
    logic             seq_err;
    logic [ERR_W-1:0] err_count;

    always #5 clk = ~clk;

    step_count_checker #(.W(W), .HOLD(HOLD), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cnt_in     (cnt_in),
        .clr_err    (clr_err),
        .step_valid (step_valid),
        .step_value (step_value),
        .locked     (locked),
        .hold_err   (hold_err),
        .seq_err    (seq_err),
        .err_count  (err_count)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: tracks samples of the current value with an unbounded count
    bit m_started, m_locked, m_sv, m_h, m_s;
    int m_prev, m_run, m_val, m_cnt;

    function automatic void model_reset();
        m_started = 0; m_locked = 0; m_sv = 0; m_h = 0; m_s = 0;
        m_prev = 0; m_run = 0; m_val = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(bit e, int c, bit k);
        int h, s;
        bit ok;
        h = 0;
        s = 0;
        m_sv = 0;
        if (e) begin
            if (!m_started) begin
                m_started = 1;
                m_prev = c;
                m_run = 1;
            end else if (c == m_prev) begin
                m_run++;
                if (m_locked && m_run == HOLD + 1) h = 1;
            end else begin
                ok = (c == (m_prev + 1) % MOD);
                m_sv = 1;
                m_val = c;
                if (m_locked && m_run < HOLD) h = 1;
                if (!ok) s = 1;
                m_locked = ok;
                m_prev = c;
                m_run = 1;
            end
        end
        if (k) begin
            m_h = 0; m_s = 0; m_cnt = 0;
        end
        if (h != 0) m_h = 1;
        if (s != 0) m_s = 1;
        m_cnt = (m_cnt + h + s > ERR_MAX) ? ERR_MAX : m_cnt + h + s;
    endfunction

    function automatic logic [13:0] obs();
        return {step_valid, step_value, locked, hold_err, seq_err, err_count};
    endfunction

    function automatic logic [13:0] expv();
        return {m_sv, 2'(m_val), m_locked, m_h, m_s, 8'(m_cnt)};
    endfunction

    task automatic tick(input bit e, input int c, input bit k);
        en = e;
        cnt_in = W'(c);
        clr_err = k;
        @(posedge clk);
        #1;
        model_step(e, c, k);
    endtask

    task automatic test_reset();
        rst = 1; en = 0; cnt_in = '0; clr_err = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (obs() !== 14'd0) $display("FAIL reset_values: got %h want %h", obs(), 14'd0);
        else n_pass++;
        rst = 0;
    endtask

    task automatic test_lock_sequence();
        int seq[$];
        int pulses[$];
        int want[4] = '{1, 2, 3, 0};
        repeat (3) seq.push_back(0);
        for (int v = 1; v <= 4; v++) repeat (5) seq.push_back(v % MOD);
        foreach (seq[i]) begin
            tick(1, seq[i], 0);
            if (step_valid === 1'b1) pulses.push_back(int'(step_value));
            n_total++;
            if (obs() !== expv()) $display("FAIL lock_seq cyc%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
        n_total++;
        if (pulses.size() != 4 || pulses[0] != want[0] || pulses[1] != want[1] ||
            pulses[2] != want[2] || pulses[3] != want[3])
            $display("FAIL lock_pulses: got %p want %p", pulses, want);
        else n_pass++;
        n_total++;
        if ({locked, hold_err, seq_err, err_count} !== {1'b1, 1'b0, 1'b0, 8'd0})
            $display("FAIL lock_final: got %b%b%b %0d want 100 0", locked, hold_err, seq_err, err_count);
        else n_pass++;
    endtask

    task automatic test_short_run();
        int seq[$];
        repeat (5) seq.push_back(1);
        repeat (3) seq.push_back(2);
        seq.push_back(3);
        foreach (seq[i]) begin
            tick(1, seq[i], 0);
            n_total++;
            if (obs() !== expv()) $display("FAIL short_run cyc%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
        n_total++;
        if ({locked, hold_err, seq_err, err_count} !== {1'b1, 1'b1, 1'b0, 8'd1})
            $display("FAIL short_run_final: got %b%b%b %0d want 110 1", locked, hold_err, seq_err, err_count);
        else n_pass++;
    endtask

    task automatic test_bad_increment();
        int seq[$];
        repeat (4) tick(1, 3, 0);
        tick(0, 0, 1);
        repeat (5) seq.push_back(0);
        seq.push_back(2);
        foreach (seq[i]) begin
            tick(1, seq[i], 0);
            n_total++;
            if (obs() !== expv()) $display("FAIL bad_inc cyc%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
        n_total++;
        if ({locked, hold_err, seq_err, err_count} !== {1'b0, 1'b0, 1'b1, 8'd1})
            $display("FAIL bad_inc_final: got %b%b%b %0d want 001 1", locked, hold_err, seq_err, err_count);
        else n_pass++;
        repeat (4) tick(1, 2, 0);
        tick(1, 3, 0);
        n_total++;
        if ({step_valid, step_value, locked, err_count} !== {1'b1, 2'd3, 1'b1, 8'd1})
            $display("FAIL relock: got %b %0d %b %0d want 1 3 1 1", step_valid, step_value, locked, err_count);
        else n_pass++;
    endtask

    task automatic test_long_run();
        tick(0, 0, 1);
        for (int i = 2; i <= 7; i++) begin
            tick(1, 3, 0);
            n_total++;
            if (obs() !== expv()) $display("FAIL long_run sample%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
            if (i == 6) begin
                n_total++;
                if ({hold_err, err_count} !== {1'b1, 8'd1})
                    $display("FAIL long_run_flag: got %b %0d want 1 1", hold_err, err_count);
                else n_pass++;
            end
        end
        tick(1, 0, 0);
        n_total++;
        if ({step_valid, step_value, err_count} !== {1'b1, 2'd0, 8'd1})
            $display("FAIL long_run_exit: got %b %0d %0d want 1 0 1", step_valid, step_value, err_count);
        else n_pass++;
    endtask

    task automatic test_double_error_and_saturation();
        int guard;
        tick(0, 0, 1);
        repeat (4) tick(1, 0, 0);
        tick(1, 1, 0);
        tick(1, 1, 0);
        tick(1, 3, 0);
        n_total++;
        if ({hold_err, seq_err, err_count, locked} !== {1'b1, 1'b1, 8'd2, 1'b0})
            $display("FAIL double_err: got %b%b %0d %b want 11 2 0", hold_err, seq_err, err_count, locked);
        else n_pass++;
        guard = 0;
        while (m_cnt < ERR_MAX && guard < 300) begin
            tick(1, (m_prev + 2) % MOD, 0);
            guard++;
            n_total++;
            if (obs() !== expv()) $display("FAIL sat_walk step%0d: got %h want %h", guard, obs(), expv());
            else n_pass++;
        end
        n_total++;
        if (err_count !== 8'd255) $display("FAIL sat_reach: got %0d want 255", err_count);
        else n_pass++;
        tick(1, (m_prev + 2) % MOD, 0);
        n_total++;
        if ({err_count, seq_err} !== {8'd255, 1'b1}) $display("FAIL sat_hold: got %0d want 255", err_count);
        else n_pass++;
    endtask

    task automatic test_enable_gap();
        int v;
        tick(0, 0, 1);
        v = (m_prev + 1) % MOD;
        repeat (2) tick(1, v, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, int'($urandom_range(0, 3)), 0);
            n_total++;
            if (obs() !== expv() || step_valid !== 1'b0)
                $display("FAIL en_gap cyc%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
        repeat (3) tick(1, v, 0);
        tick(1, (v + 1) % MOD, 0);
        n_total++;
        if ({step_valid, locked, hold_err, err_count} !== {1'b1, 1'b1, 1'b0, 8'd0})
            $display("FAIL en_gap_run: got %b%b%b %0d want 110 0", step_valid, locked, hold_err, err_count);
        else n_pass++;
    endtask

    task automatic test_clear_coincident();
        tick(1, (m_prev + 3) % MOD, 0);
        n_total++;
        if (obs() !== expv()) $display("FAIL pre_clear: got %h want %h", obs(), expv());
        else n_pass++;
        tick(1, (m_prev + 2) % MOD, 1);
        n_total++;
        if ({hold_err, seq_err, err_count} !== {1'b0, 1'b1, 8'd1})
            $display("FAIL clear_coincident: got %b%b %0d want 01 1", hold_err, seq_err, err_count);
        else n_pass++;
    endtask

    task automatic test_random();
        int cur, left, c;
        bit e, k;
        cur = (m_prev + 1) % MOD;
        left = HOLD;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 7) != 0);
            k = ($urandom_range(0, 29) == 0);
            c = cur;
            if (e) begin
                if ($urandom_range(0, 19) == 0) begin
                    c = int'($urandom_range(0, 3));
                end else begin
                    left--;
                    if (left == 0) begin
                        cur = (cur + 1) % MOD;
                        left = HOLD;
                    end
                end
            end
            tick(e, c, k);
            n_total++;
            if (obs() !== expv()) $display("FAIL random cyc%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        repeat (3) tick(1, (m_prev + 1) % MOD, 0);
        #2 rst = 1;
        #1;
        model_reset();
        n_total++;
        if (obs() !== 14'd0) $display("FAIL async_reset: got %h want %h", obs(), 14'd0);
        else n_pass++;
        en = 1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (obs() !== 14'd0) $display("FAIL reset_held: got %h want %h", obs(), 14'd0);
        else n_pass++;
        rst = 0;
        for (int i = 0; i < 7; i++) begin
            tick(1, (i < 2) ? 2 : 3, 0);
            n_total++;
            if (obs() !== expv()) $display("FAIL post_reset cyc%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_short_run();
        test_bad_increment();
        test_long_run();
        test_double_error_and_saturation();
        test_enable_gap();
        test_clear_coincident();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/step_count_checker.md
Name: step_count_checker

Overview:
- Downstream monitor for a stepped counter: the count input holds each value for exactly HOLD cycles, then increments by 1 modulo 2^W.
- Samples the count on enabled cycles and emits a one-cycle step event carrying each new value.
- Checks run length and increment sequence, and keeps sticky error flags plus a saturating error count.
- Sits directly after the repeat-count generator and feeds the step stream to the consumers that follow.

Parameters:
W, 2, count width
HOLD, 5, required cycles per value (>=2)
ERR_W, 8, error counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  sample enable; cnt_in is ignored when en=0
cnt_in  in  W  stepped count under observation
clr_err  in  1  synchronous clear of hold_err, seq_err and err_count
step_valid  out  1  one-cycle pulse: a new value was sampled
step_value  out  W  new value; valid while step_valid=1, otherwise holds the last value
locked  out  1  1 while state=TRACK
hold_err  out  1  sticky: a run was shorter or longer than HOLD
seq_err  out  1  sticky: a change was not +1 mod 2^W
err_count  out  ERR_W  total errors, saturating at 2^ERR_W-1

Behaviour:
- Reset values: state=IDLE; all outputs 0; internal prev=0, run_len=0, long_flag=0. Reset is asserted asynchronously and may occur mid-operation; every register returns to its reset value.
- en=0: no register changes except the clr_err effect; step_valid=0.
- run_len: width clog2(HOLD+2). Saturates at HOLD+1 and never wraps.
- "Change" means en=1 and cnt_in!=prev. "Increment OK" means cnt_in==prev+1 mod 2^W, with wrap from 2^W-1 to 0.
- Outputs are registered. step_valid, step_value, error flags and err_count update on the clock edge that samples the event (1-cycle latency from cnt_in).

State machine:
- IDLE: on en=1, prev<=cnt_in, run_len<=1, go to ACQUIRE. No step_valid, no errors.
- ACQUIRE (first run may be partial; its length is not checked):
  - same value: run_len++.
  - change with increment OK: step_valid=1, step_value=cnt_in, prev<=cnt_in, run_len<=1, go to TRACK.
  - change with bad increment: seq_err, step_valid=1, prev<=cnt_in, run_len<=1, stay in ACQUIRE.
- TRACK:
  - same value: run_len++. When run_len==HOLD and the value repeats again, raise hold_err (long run) once per run via long_flag.
  - change:
    - step_valid=1, step_value=cnt_in.
    - If run_len<HOLD, raise hold_err (short run).
    - If increment is bad, raise seq_err and go to ACQUIRE; otherwise stay in TRACK.
    - prev<=cnt_in, run_len<=1, long_flag<=0.

Error accounting:
- err_count adds the number of errors in the cycle: 0, 1 or 2, since a short run and a bad increment can coincide. Saturates and does not wrap.
- clr_err=1: flags and count clear. An error raised in the same cycle is still recorded after the clear, so the flag is set and err_count equals that cycle's error count.
- clr_err does not affect state, prev or run_len.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ACQUIRE, TRACK}
  - a clog2 function
  - an ERR_MAX constant function of ERR_W
- One natural sub-module: sat_counter (parameterised width, increment amount 0..2, sync clear, saturate). Used for run_len (increment 1, clear via load 1) and err_count.
- The FSM and change/increment compare stay in the top level.

Test Plan (W=2, HOLD=5, en=1 unless stated):
1. Reset, then cnt_in 0×3 (partial run), 1×5, 2×5, 3×5, 0×5 → step_valid pulses with step_value 1,2,3,0 one cycle after each change; locked=1 from the first pulse; no errors; err_count=0.
2. While locked, feed 1×5 then 2×3 then 3 → hold_err=1 at the 3 sample; err_count=1; locked stays 1; seq_err=0.
3. While locked, feed 2×5 then 0 → seq_err=1, hold_err=0, state=ACQUIRE (locked=0), err_count+1. Next 1 after a full run → locked=1 again.
4. While locked, feed 3×7 → hold_err set on the 6th sample only (err_count +1, not +2). Then 0 → step_value=0 with no further error.
5. Short run plus bad increment: 1×2 then 3 → hold_err=1, seq_err=1, err_count +2 in one cycle. Drive errors until err_count=255, then one more error → stays 255.
6. Toggle en=0 for 3 cycles mid-run → run_len frozen, no pulses. Assert clr_err coincident with an error → flags reflect only that cycle, err_count=1. Assert rst mid-run → all outputs 0, state IDLE immediately (asynchronous).
